// File: rtl/add_arbiter4.sv
// add_arbiter4: four-way round-robin front end for one shared 32-bit adder.
// It accepts one add request at a time from requesters 0..3, drives the
// external adder for one cycle, and holds the registered result until the
// consumer takes it. Each requester has a stored carry bit so that it can
// chain multi-word additions.
//
// Ports:
//   clk, rst_n           clock (rising edge) and async active-low reset
//   req_valid/req_ready  per-requester handshake (req_ready is one-hot or zero)
//   req_a, req_b         operands, requester i on bits [32i+31:32i]
//   req_cin, req_chain   per-requester carry-in / select the stored carry
//   add_a/add_b/add_cin  operands presented to the shared adder
//   add_s/add_cout       combinational result from the shared adder
//   rsp_valid/rsp_ready  result handshake
//   rsp_sum/rsp_cout     registered sum and carry-out
//   rsp_id               index of the requester that produced the result
module add_arbiter4 #(
    parameter int unsigned RR_INIT = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req_valid,
    output logic [3:0]   req_ready,
    input  logic [127:0] req_a,
    input  logic [127:0] req_b,
    input  logic [3:0]   req_cin,
    input  logic [3:0]   req_chain,
    output logic [31:0]  add_a,
    output logic [31:0]  add_b,
    output logic         add_cin,
    input  logic [31:0]  add_s,
    input  logic         add_cout,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [31:0]  rsp_sum,
    output logic         rsp_cout,
    output logic [1:0]   rsp_id
);

    localparam logic [1:0] PTR_INIT = 2'(RR_INIT);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        RSP
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [1:0]  ptr;
    logic [3:0]  cy_q;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_cin;
    logic [1:0]  op_id;

    logic        grant_hit;
    logic [1:0]  grant_id;

    // Round-robin search: first valid requester at or above ptr, wrapping.
    always_comb begin
        logic [1:0] idx;
        grant_hit = 1'b0;
        grant_id  = '0;
        idx       = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!grant_hit && req_valid[idx]) begin
                grant_hit = 1'b1;
                grant_id  = idx;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_hit) state_next = ADD;
            ADD:     state_next = RSP;
            RSP:     if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs; the adder operands always reflect the last captured request,
    // so they are stable outside ADD as well.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && grant_hit) begin
            req_ready[grant_id] = 1'b1;
        end
        rsp_valid = (state == RSP);
        add_a     = op_a;
        add_b     = op_b;
        add_cin   = op_cin;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= PTR_INIT;
            cy_q     <= '0;
            op_a     <= '0;
            op_b     <= '0;
            op_cin   <= 1'b0;
            op_id    <= '0;
            rsp_sum  <= '0;
            rsp_cout <= 1'b0;
            rsp_id   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_hit) begin
                        op_a   <= req_a[{grant_id, 5'd0} +: 32];
                        op_b   <= req_b[{grant_id, 5'd0} +: 32];
                        op_cin <= req_chain[grant_id] ? cy_q[grant_id]
                                                      : req_cin[grant_id];
                        op_id  <= grant_id;
                    end
                end
                ADD: begin
                    rsp_sum      <= add_s;
                    rsp_cout     <= add_cout;
                    rsp_id       <= op_id;
                    cy_q[op_id]  <= add_cout;
                end
                RSP: begin
                    // Pointer advances past the requester just served.
                    if (rsp_ready) begin
                        ptr <= rsp_id + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_add_arbiter4.sv
// Testbench for add_arbiter4: directed scenarios plus a randomized phase,
// all checked every cycle against a transaction-level reference model.
module tb_add_arbiter4;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   req_cin;
    logic [3:0]   req_chain;
    logic [31:0]  add_a;
    logic [31:0]  add_b;
    logic         add_cin;
    logic [31:0]  add_s;
    logic         add_cout;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [31:0]  rsp_sum;
    logic         rsp_cout;
    logic [1:0]   rsp_id;

    add_arbiter4 #(.RR_INIT(0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_chain (req_chain),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_s     (add_s),
        .add_cout  (add_cout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_id    (rsp_id)
    );

    // The shared adder lives outside the arbiter.
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int          m_ptr;
    logic        m_cy [4];
    int          m_age;      // -1 idle, 0 adder cycle, >=1 result pending
    logic [31:0] m_a, m_b, m_sum;
    logic        m_cin, m_cout;
    int          m_id;

    // Observations from the most recent cycle
    logic        o_valid, o_cout;
    logic [31:0] o_sum;
    logic [1:0]  o_id;
    int          ncyc = 0;
    int          hs_ids[$];
    int          hs_t[$];

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_ptr = 0;
        for (int i = 0; i < 4; i++) m_cy[i] = 1'b0;
        m_age = -1;
        m_a = '0; m_b = '0; m_cin = 1'b0;
        m_sum = '0; m_cout = 1'b0; m_id = 0;
    endfunction

    // Called at posedge+1 with inputs already set; returns at next posedge+1.
    task automatic cycle();
        int g;
        logic [3:0] er;
        longint unsigned s;
        #2;
        er = '0;
        g = -1;
        if (m_age < 0) begin
            g = pick(req_valid, m_ptr);
            if (g >= 0) er[g] = 1'b1;
        end
        chk("req_ready", 96'(req_ready), 96'(er));
        chk("rsp_valid", 96'(rsp_valid), 96'(m_age >= 1));
        chk("add_ops", 96'({add_a, add_b, add_cin}), 96'({m_a, m_b, m_cin}));
        if (m_age >= 1) begin
            chk("rsp_sum", 96'(rsp_sum), 96'(m_sum));
            chk("rsp_cout", 96'(rsp_cout), 96'(m_cout));
            chk("rsp_id", 96'(rsp_id), 96'(m_id));
        end
        o_valid = rsp_valid; o_sum = rsp_sum; o_cout = rsp_cout; o_id = rsp_id;
        if (rsp_valid && rsp_ready) begin
            hs_ids.push_back(int'(rsp_id));
            hs_t.push_back(ncyc);
        end
        @(posedge clk);
        ncyc++;
        if (m_age < 0) begin
            if (g >= 0) begin
                m_a   = req_a[32*g +: 32];
                m_b   = req_b[32*g +: 32];
                m_cin = req_chain[g] ? m_cy[g] : req_cin[g];
                m_id  = g;
                m_age = 0;
            end
        end else if (m_age == 0) begin
            s = longint'(m_a) + longint'(m_b) + longint'(m_cin);
            m_sum  = s[31:0];
            m_cout = s[32];
            m_cy[m_id] = m_cout;
            m_age = 1;
        end else if (rsp_ready) begin
            m_ptr = (m_id + 1) % 4;
            m_age = -1;
        end else begin
            m_age++;
        end
        #1;
    endtask

    // Asserted mid-cycle so the asynchronous clear is observed before any edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_rsp_valid", 96'(rsp_valid), 96'(0));
        chk("rst_rsp_sum", 96'(rsp_sum), 96'(0));
        chk("rst_rsp_cout", 96'(rsp_cout), 96'(0));
        chk("rst_rsp_id", 96'(rsp_id), 96'(0));
        chk("rst_add_ops", 96'({add_a, add_b, add_cin}), 96'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Issue the currently set request, then wait (bounded) for its result.
    task automatic run_op(input string tag, input int exp_lat);
        int n;
        cycle();
        req_valid = '0;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!o_valid && n < 10);
        chk({tag, "_latency"}, 96'(n), 96'(exp_lat));
    endtask

    initial begin
        int n0;
        logic [31:0] s0;
        rst_n = 1'b0;
        req_valid = '0; req_a = '0; req_b = '0;
        req_cin = '0; req_chain = '0; rsp_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Idle: nothing requested for 10 cycles
        rsp_ready = 1'b1;
        repeat (10) cycle();

        // Single request with overflow
        req_a[31:0] = 32'hFFFF_FFFF;
        req_b[31:0] = 32'h0000_0001;
        req_cin = '0; req_chain = '0;
        req_valid = 4'b0001;
        run_op("single", 2);
        chk("single_sum", 96'(o_sum), 96'(32'h0));
        chk("single_cout", 96'(o_cout), 96'(1));
        chk("single_id", 96'(o_id), 96'(0));
        cycle();

        // Round robin with all requesters pending
        do_reset();
        hs_ids.delete(); hs_t.delete();
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            req_a = {$urandom, $urandom, $urandom, $urandom};
            req_b = {$urandom, $urandom, $urandom, $urandom};
            req_cin = 4'($urandom);
            cycle();
        end
        chk("rr_count", 96'(hs_ids.size() >= 5), 96'(1));
        if (hs_ids.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                chk("rr_id", 96'(hs_ids[i]), 96'(i % 4));
                if (i > 0) chk("rr_spacing", 96'(hs_t[i] - hs_t[i-1]), 96'(3));
            end
        end

        // Carry chaining on requester 2
        req_valid = '0;
        do_reset();
        req_a = '0; req_b = '0; req_cin = '0; req_chain = '0;
        req_a[95:64] = 32'h8000_0000;
        req_b[95:64] = 32'h8000_0000;
        req_valid = 4'b0100;
        run_op("chain1", 2);
        chk("chain1_sum", 96'(o_sum), 96'(32'h0));
        chk("chain1_cout", 96'(o_cout), 96'(1));
        req_a = '0; req_b = '0; req_chain = 4'b0100;
        req_valid = 4'b0100;
        run_op("chain2", 2);
        chk("chain2_sum", 96'(o_sum), 96'(32'h1));
        chk("chain2_cout", 96'(o_cout), 96'(0));
        for (int r = 0; r < 4; r++) begin
            if (r != 2) begin
                req_chain = 4'hF;
                req_valid = '0;
                req_valid[r] = 1'b1;
                run_op("chain_other", 2);
                chk("chain_other_sum", 96'(o_sum), 96'(32'h0));
                chk("chain_other_id", 96'(o_id), 96'(r));
            end
        end
        req_chain = '0;
        cycle();

        // Backpressure: result held for 5 cycles while others wait
        req_a = {$urandom, $urandom, $urandom, $urandom};
        req_b = {$urandom, $urandom, $urandom, $urandom};
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        cycle();
        req_valid = 4'hF;
        cycle();
        n0 = hs_ids.size();
        cycle();
        s0 = o_sum;
        repeat (4) cycle();
        chk("bp_hold_sum", 96'(o_sum), 96'(s0));
        chk("bp_no_handshake", 96'(hs_ids.size()), 96'(n0));
        rsp_ready = 1'b1;
        req_valid = '0;
        cycle();
        chk("bp_release", 96'(hs_ids.size()), 96'(n0 + 1));
        cycle();

        // Reset while the adder cycle is in progress (pointer currently 1)
        req_a = '1; req_b = '0; req_cin = 4'hF; req_chain = '0;
        req_valid = 4'b0010;
        cycle();
        do_reset();
        req_valid = '0;
        n0 = hs_ids.size();
        repeat (5) cycle();
        chk("abort_no_rsp", 96'(hs_ids.size()), 96'(n0));
        req_a = '0; req_b = '0; req_chain = 4'hF;
        req_valid = 4'hF;
        run_op("post_reset", 2);
        chk("post_reset_id", 96'(o_id), 96'(0));
        chk("post_reset_sum", 96'(o_sum), 96'(0));
        req_valid = 4'b0010;
        run_op("post_reset_cy1", 2);
        chk("post_reset_cy1_sum", 96'(o_sum), 96'(0));
        cycle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            req_valid = 4'($urandom);
            req_chain = 4'($urandom);
            req_cin   = 4'($urandom);
            req_a     = {$urandom, $urandom, $urandom, $urandom};
            req_b     = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 3) == 0) begin
                req_a[31:0]   = 32'hFFFF_FFFF;
                req_b[95:64]  = 32'h8000_0000;
                req_a[95:64]  = 32'h8000_0000;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) do_reset();
            else cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
